// File: rtl/alu_cycle_seq_pkg.sv
// Shared types for the multi-cycle ALU sequencer: op kind, FSM state, default cycle counts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_cycle_seq_pkg;

   // How many cycles the ALU needs for the op that decode is presenting.
   typedef enum logic [1:0] {
      ACK_SINGLE = 2'd0,
      ACK_MUL    = 2'd1,
      ACK_DIV    = 2'd2
   } Alu_cycle_kind;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

   // Total cycles per op, issue cycle included.
   localparam int MUL_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF = 32;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/alu_cycle_seq_if.sv
// Decode <-> sequencer bus: issue request and stall/flush in, ALU sequencing fields out.
// Latency: n/a (wiring only).
// Backpressure: stall_req tells decode to hold; stall_in freezes the sequencer.
interface alu_cycle_seq_if;
   import alu_cycle_seq_pkg::*;

   logic          issue_en;
   Alu_cycle_kind issue_kind;
   logic          stall_in;
   logic          flush;
   logic          done_early;
   logic          multi_cycle;
   logic          last_cycle;
   logic          stall_req;
   logic          busy;

   // Decode / pipeline control side.
   modport master (
      output issue_en, issue_kind, stall_in, flush, done_early,
      input  multi_cycle, last_cycle, stall_req, busy
   );

   // Sequencer side.
   modport slave (
      input  issue_en, issue_kind, stall_in, flush, done_early,
      output multi_cycle, last_cycle, stall_req, busy
   );

endinterface

// File: rtl/alu_cycle_seq.sv
// Sequences multi-cycle ALU ops (mul/div): drives multi_cycle/last_cycle and holds decode via stall_req.
// Latency: outputs are combinational from state/cnt and the issue inputs; an op spans N cycles from accept.
// Backpressure: stall_in freezes state and count; flush aborts; optional ALU_EARLY_OUT_EN honours done_early.
module alu_cycle_seq
   import alu_cycle_seq_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = $clog2(max_int(MUL_CYCLES, DIV_CYCLES))
) (
   input  logic         clk,
   input  logic         reset,
   alu_cycle_seq_if.slave bus
);

   // Both op lengths include the issue cycle and at least one RUN cycle.
   generate
      if (MUL_CYCLES < 2) begin : g_bad_mul
         $error("alu_cycle_seq: MUL_CYCLES must be >= 2");
      end
      if (DIV_CYCLES < 2) begin : g_bad_div
         $error("alu_cycle_seq: DIV_CYCLES must be >= 2");
      end
   endgenerate

   seq_state_e       state;
   logic [CNT_W-1:0] cnt;        // remaining RUN cycles after the current one
   logic             is_multi;
   logic             accept;
   logic [CNT_W-1:0] load_val;

   // Decide whether decode's op starts a multi-cycle sequence this cycle and how long it runs.
   always_comb begin
      is_multi = (bus.issue_kind == ACK_MUL) || (bus.issue_kind == ACK_DIV);
      accept   = reset && (state == ST_IDLE) && bus.issue_en && is_multi &&
                 !bus.stall_in && !bus.flush;
      load_val = (bus.issue_kind == ACK_DIV) ? CNT_W'(DIV_CYCLES - 2)
                                             : CNT_W'(MUL_CYCLES - 2);
   end

`ifdef ALU_EARLY_OUT_EN
   logic early_hit;
   // ALU finished ahead of the nominal count: make the next cycle the last one.
   always_comb early_hit = bus.done_early && (cnt > CNT_W'(1));
`endif

   // State and down-counter; flush wins over everything, stall_in freezes RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (bus.flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (accept) begin
         state <= ST_RUN;
         cnt   <= load_val;
      end else if ((state == ST_RUN) && !bus.stall_in) begin
         if (cnt == '0) begin
            state <= ST_IDLE;
         end
`ifdef ALU_EARLY_OUT_EN
         else if (early_hit) begin
            cnt <= '0;
         end
`endif
         else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Sequencing fields: the accept cycle only raises stall_req; RUN covers cycles 2..N.
   always_comb begin
      bus.busy        = (state == ST_RUN);
      bus.multi_cycle = (state == ST_RUN);
      bus.last_cycle  = (state == ST_RUN) && (cnt == '0);
      bus.stall_req   = (state == ST_RUN) ? (cnt != '0) : accept;
   end

   // Decode must not present a new op while it is being told to hold.
   issue_during_hold_a: assert property (@(posedge clk) disable iff (!reset)
      !((state == ST_RUN) && bus.stall_req && !bus.flush && bus.issue_en));

endmodule

// File: tb/tb_alu_cycle_seq.sv
// Self-checking bench for alu_cycle_seq: table of vectors plus hand-written multi-cycle sequences.
// Latency: each vector is driven on the falling edge and its outputs sampled 2 ns later.
// Backpressure: exercises stall_in extension, flush abort and optional early-out.
module tb_alu_cycle_seq;
   import alu_cycle_seq_pkg::*;

   logic clk = 1'b0;
   logic reset;

   alu_cycle_seq_if bus();

   alu_cycle_seq #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Expected outputs packed as {multi_cycle, last_cycle, stall_req, busy}.
   localparam logic [3:0] O_NONE = 4'b0000;
   localparam logic [3:0] O_ACC  = 4'b0010;
   localparam logic [3:0] O_MID  = 4'b1011;
   localparam logic [3:0] O_LAST = 4'b1101;

   typedef struct {
      logic          rst_n;
      logic          en;
      Alu_cycle_kind kind;
      logic          stl;
      logic          fl;
      logic          de;
      logic [3:0]    exp;
      int            id;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   vec_t cur;
   logic [3:0] got;
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   function automatic string nm(input int id);
      case (id)
         0:  return "reset";
         1:  return "mul_run";
         2:  return "single";
         3:  return "flush_accept";
         4:  return "b2b_mul";
         5:  return "b2b_div";
         6:  return "early_out";
         7:  return "mul_stall";
         8:  return "div_flush";
         9:  return "div_after_flush";
         10: return "reset_mid_run";
         11: return "mul_after_reset";
         default: return "idle";
      endcase
   endfunction

   function automatic vec_t mk(input logic r, input logic en, input Alu_cycle_kind k,
                               input logic stl, input logic fl, input logic de,
                               input logic [3:0] e, input int id);
      vec_t v;
      v.rst_n = r; v.en = en; v.kind = k; v.stl = stl; v.fl = fl; v.de = de;
      v.exp = e; v.id = id;
      return v;
   endfunction

   function automatic vec_t idle(input logic [3:0] e, input int id);
      return mk(1'b1, 1'b0, ACK_SINGLE, 1'b0, 1'b0, 1'b0, e, id);
   endfunction

   // Full uninterrupted op of n cycles appended to the table.
   task automatic add_run(input Alu_cycle_kind k, input int n, input int id);
      tbl.push_back(mk(1'b1, 1'b1, k, 1'b0, 1'b0, 1'b0, O_ACC, id));
      for (int j = 1; j < n - 1; j++) tbl.push_back(idle(O_MID, id));
      tbl.push_back(idle(O_LAST, id));
   endtask

   // Drive one vector and hand its expectation to the scoreboard.
   task automatic step(input vec_t v);
      @(negedge clk);
      reset          = v.rst_n;
      bus.issue_en   = v.en;
      bus.issue_kind = v.kind;
      bus.stall_in   = v.stl;
      bus.flush      = v.fl;
      bus.done_early = v.de;
      exp_q.push_back(v);
      cyc++;
   endtask

   task automatic run_op(input Alu_cycle_kind k, input int n, input int id);
      step(mk(1'b1, 1'b1, k, 1'b0, 1'b0, 1'b0, O_ACC, id));
      for (int j = 1; j < n - 1; j++) step(idle(O_MID, id));
      step(idle(O_LAST, id));
   endtask

   // Scoreboard: pop the expectation for the vector driven on this falling edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            got = {bus.multi_cycle, bus.last_cycle, bus.stall_req, bus.busy};
            checks++;
            if (got !== cur.exp) begin
               failures++;
               $display("FAIL %s cyc=%0d got(m,l,s,b)=%b exp=%b", nm(cur.id), cyc, got, cur.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b0;
      bus.issue_en   = 1'b0;
      bus.issue_kind = ACK_SINGLE;
      bus.stall_in   = 1'b0;
      bus.flush      = 1'b0;
      bus.done_early = 1'b0;

      // Reset state, including an issue request that must be ignored under reset.
      tbl.push_back(mk(1'b0, 1'b0, ACK_SINGLE, 1'b0, 1'b0, 1'b0, O_NONE, 0));
      tbl.push_back(mk(1'b0, 1'b1, ACK_MUL,    1'b0, 1'b0, 1'b0, O_NONE, 0));
      tbl.push_back(idle(O_NONE, 12));
      // Plain multiply: stall_req t0..t2, multi/busy t1..t3, last t3.
      add_run(ACK_MUL, 4, 1);
      tbl.push_back(idle(O_NONE, 1));
      // Single-cycle op passes through untouched.
      tbl.push_back(mk(1'b1, 1'b1, ACK_SINGLE, 1'b0, 1'b0, 1'b0, O_NONE, 2));
      tbl.push_back(idle(O_NONE, 2));
      // Flush in the accept cycle blocks the accept.
      tbl.push_back(mk(1'b1, 1'b1, ACK_MUL, 1'b0, 1'b1, 1'b0, O_NONE, 3));
      tbl.push_back(idle(O_NONE, 3));
      // MUL, DIV presented on MUL's last cycle (not accepted), re-presented at t4.
      tbl.push_back(mk(1'b1, 1'b1, ACK_MUL, 1'b0, 1'b0, 1'b0, O_ACC, 4));
      tbl.push_back(idle(O_MID, 4));
      tbl.push_back(idle(O_MID, 4));
      tbl.push_back(mk(1'b1, 1'b1, ACK_DIV, 1'b0, 1'b0, 1'b0, O_LAST, 4));
      add_run(ACK_DIV, 32, 5);
      tbl.push_back(idle(O_NONE, 5));
      // Divide with done_early at t4.
      tbl.push_back(mk(1'b1, 1'b1, ACK_DIV, 1'b0, 1'b0, 1'b0, O_ACC, 6));
      for (int j = 1; j <= 3; j++) tbl.push_back(idle(O_MID, 6));
      tbl.push_back(mk(1'b1, 1'b0, ACK_SINGLE, 1'b0, 1'b0, 1'b1, O_MID, 6));
`ifdef ALU_EARLY_OUT_EN
      tbl.push_back(idle(O_LAST, 6));
`else
      for (int j = 5; j <= 30; j++) tbl.push_back(idle(O_MID, 6));
      tbl.push_back(idle(O_LAST, 6));
`endif
      tbl.push_back(idle(O_NONE, 6));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Multiply with stall_in at t2..t3: outputs repeat, last moves to t5.
      step(mk(1'b1, 1'b1, ACK_MUL, 1'b0, 1'b0, 1'b0, O_ACC, 7));
      step(idle(O_MID, 7));
      step(mk(1'b1, 1'b0, ACK_SINGLE, 1'b1, 1'b0, 1'b0, O_MID, 7));
      step(mk(1'b1, 1'b0, ACK_SINGLE, 1'b1, 1'b0, 1'b0, O_MID, 7));
      step(idle(O_MID, 7));
      step(idle(O_LAST, 7));
      step(idle(O_NONE, 7));

      // Divide flushed at t5: t6 quiet.
      step(mk(1'b1, 1'b1, ACK_DIV, 1'b0, 1'b0, 1'b0, O_ACC, 8));
      for (int j = 1; j <= 4; j++) step(idle(O_MID, 8));
      step(mk(1'b1, 1'b0, ACK_SINGLE, 1'b0, 1'b1, 1'b0, O_MID, 8));
      step(idle(O_NONE, 8));

      // Divide flushed at t5, new divide at t6 ends at t37.
      step(mk(1'b1, 1'b1, ACK_DIV, 1'b0, 1'b0, 1'b0, O_ACC, 8));
      for (int j = 1; j <= 4; j++) step(idle(O_MID, 8));
      step(mk(1'b1, 1'b0, ACK_SINGLE, 1'b0, 1'b1, 1'b0, O_MID, 8));
      run_op(ACK_DIV, 32, 9);
      step(idle(O_NONE, 9));

      // Reset pulled low on cycle 3 of a multiply, then a fresh multiply.
      step(mk(1'b1, 1'b1, ACK_MUL, 1'b0, 1'b0, 1'b0, O_ACC, 10));
      step(idle(O_MID, 10));
      step(mk(1'b0, 1'b0, ACK_SINGLE, 1'b0, 1'b0, 1'b0, O_NONE, 10));
      step(mk(1'b0, 1'b0, ACK_SINGLE, 1'b0, 1'b0, 1'b0, O_NONE, 10));
      step(idle(O_NONE, 10));
      run_op(ACK_MUL, 4, 11);
      step(idle(O_NONE, 11));

      // Let the scoreboard drain, bounded.
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
